sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator_pkg.sv | 16 +
 rtl/sat_add.sv | 21 ++
 rtl/sum_accumulator.sv | 114 +++++++++++
 tb/tb_sum_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared types and constants for the sum accumulator: FSM state encoding,
// upstream adder sum width and default frame geometry.
package sum_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int SUM_W           = 5;
    localparam int CNT_W           = 8;
    localparam int DEF_NUM_SAMPLES = 4;
    localparam int DEF_ACC_W       = 8;

endpackage

// File: rtl/sat_add.sv
// Saturating add of a zero-extended SUM_W-bit sample onto an ACC_W-bit
// accumulator; clamps to all-ones and flags overflow when the true sum exceeds it.
module sat_add
    import sum_accumulator_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [SUM_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] wide;

    // One extra bit catches the carry out; ACC_W >= SUM_W so the sample always fits.
    assign wide  = {1'b0, a_i} + (ACC_W+1)'(b_i);
    assign ovf_o = wide[ACC_W];
    assign sum_o = ovf_o ? '1 : wide[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums NUM_SAMPLES upstream adder results with valid/ready
// handshakes on both sides, saturating at 2^ACC_W-1.
//   state    | meaning
//   ST_IDLE  | waiting for start, no handshakes active
//   ST_ACCUM | accepting samples into the accumulator
//   ST_HOLD  | frame result presented until downstream takes it
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int ACC_W       = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   sat_sum;
    logic               sat_ovf;
    logic [CNT_W-1:0]   cnt_inc;

    sat_add #(
        .ACC_W(ACC_W)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (sum_in),
        .sum_o (sat_sum),
        .ovf_o (sat_ovf)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (sum_valid) begin
                        acc_d = sat_sum;
                        ovf_d = ovf_q | sat_ovf;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(NUM_SAMPLES)) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Downstream take restarts directly so frames can stream back to back.
                    if (acc_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign sum_ready = (state_q == ST_ACCUM);
    assign busy      = (state_q == ST_ACCUM);
    assign acc_valid = (state_q == ST_HOLD);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an 8-bit and a 5-bit accumulator share
// stimulus; expected values are hand-computed per scenario.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clear;
    logic [4:0] sum_in;
    logic       sum_valid;
    logic       acc_ready;

    logic       sum_ready, acc_valid, ovf, busy;
    logic [7:0] acc_out;
    logic       sum_ready5, acc_valid5, ovf5, busy5;
    logic [4:0] acc_out5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.NUM_SAMPLES(4), .ACC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .ovf(ovf), .busy(busy)
    );

    sum_accumulator #(.NUM_SAMPLES(4), .ACC_W(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready5),
        .acc_out(acc_out5), .acc_valid(acc_valid5), .acc_ready(acc_ready),
        .ovf(ovf5), .busy(busy5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        start = 0; sum_valid = 0; acc_ready = 0; clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; clear = 0; sum_in = 0; sum_valid = 0; acc_ready = 0;
        #2;
        checks++; if (acc_out !== 8'd0) begin errors++; $display("FAIL reset_acc_out: got %0d expected 0", acc_out); end
        checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid: got %b expected 0", acc_valid); end
        checks++; if (sum_ready !== 1'b0) begin errors++; $display("FAIL reset_sum_ready: got %b expected 0", sum_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick(); tick();
        rst = 0;
        tick();
        checks++; if (sum_ready !== 1'b0) begin errors++; $display("FAIL idle_sum_ready: got %b expected 0", sum_ready); end
    endtask

    task automatic test_basic();
        logic [4:0] v [4];
        v[0] = 3; v[1] = 7; v[2] = 12; v[3] = 30;
        do_start();
        checks++; if (sum_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_accum_entry: got ready=%b busy=%b expected 1 1", sum_ready, busy); end
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = v[i];
            tick();
            if (i == 2) begin
                checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", acc_valid); end
            end
        end
        sum_valid = 0;
        checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL basic_acc_valid: got %b expected 1", acc_valid); end
        checks++; if (acc_out !== 8'd52) begin errors++; $display("FAIL basic_acc_out: got %0d expected 52", acc_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
        checks++; if (sum_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold_flags: got ready=%b busy=%b expected 0 0", sum_ready, busy); end
        go_idle();
    endtask

    task automatic test_gaps();
        logic [4:0] v [7];
        v[0] = 2; v[1] = 9; v[2] = 4; v[3] = 9; v[4] = 6; v[5] = 9; v[6] = 8;
        do_start();
        for (int i = 0; i < 7; i++) begin
            sum_valid = (i % 2 == 0); sum_in = v[i];
            tick();
            if (i == 5) begin
                checks++; if (acc_valid !== 1'b0 || acc_out !== 8'd12) begin errors++; $display("FAIL gaps_partial: got valid=%b acc=%0d expected 0 12", acc_valid, acc_out); end
            end
        end
        checks++; if (acc_valid !== 1'b1 || acc_out !== 8'd20) begin errors++; $display("FAIL gaps_result: got valid=%b acc=%0d expected 1 20", acc_valid, acc_out); end
        sum_valid = 1; sum_in = 9; start = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (acc_valid !== 1'b1 || acc_out !== 8'd20 || sum_ready !== 1'b0) begin
                errors++; $display("FAIL gaps_hold_stable: got valid=%b acc=%0d ready=%b expected 1 20 0", acc_valid, acc_out, sum_ready);
            end
        end
        start = 0;
        go_idle();
    endtask

    task automatic test_saturate();
        logic [4:0] v [4];
        v[0] = 20; v[1] = 20; v[2] = 0; v[3] = 0;
        do_start();
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = v[i];
            tick();
            if (i == 1) begin
                checks++; if (ovf5 !== 1'b1 || acc_out5 !== 5'd31) begin errors++; $display("FAIL sat_mid: got ovf=%b acc=%0d expected 1 31", ovf5, acc_out5); end
            end
        end
        sum_valid = 0;
        checks++; if (acc_valid5 !== 1'b1 || acc_out5 !== 5'd31 || ovf5 !== 1'b1) begin errors++; $display("FAIL sat_result5: got valid=%b acc=%0d ovf=%b expected 1 31 1", acc_valid5, acc_out5, ovf5); end
        checks++; if (acc_out !== 8'd40 || ovf !== 1'b0) begin errors++; $display("FAIL sat_result8: got acc=%0d ovf=%b expected 40 0", acc_out, ovf); end
        acc_ready = 1;
        tick();
        acc_ready = 0;
        checks++; if (ovf5 !== 1'b0 || acc_out5 !== 5'd0 || busy5 !== 1'b1) begin errors++; $display("FAIL sat_restart: got ovf=%b acc=%0d busy=%b expected 0 0 1", ovf5, acc_out5, busy5); end
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = 1;
            tick();
        end
        sum_valid = 0;
        checks++; if (acc_valid5 !== 1'b1 || acc_out5 !== 5'd4 || ovf5 !== 1'b0) begin errors++; $display("FAIL sat_next_frame: got valid=%b acc=%0d ovf=%b expected 1 4 0", acc_valid5, acc_out5, ovf5); end
        go_idle();
    endtask

    task automatic test_clear();
        do_start();
        sum_valid = 1; sum_in = 5; tick();
        sum_in = 6; tick();
        checks++; if (acc_out !== 8'd11) begin errors++; $display("FAIL clear_partial: got %0d expected 11", acc_out); end
        clear = 1; start = 1; sum_in = 7;
        tick();
        clear = 0; start = 0;
        checks++; if (sum_ready !== 1'b0 || acc_out !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL clear_idle: got ready=%b acc=%0d busy=%b expected 0 0 0", sum_ready, acc_out, busy); end
        tick();
        checks++; if (sum_ready !== 1'b0 || acc_out !== 8'd0) begin errors++; $display("FAIL clear_stays_idle: got ready=%b acc=%0d expected 0 0", sum_ready, acc_out); end
        sum_valid = 0;
        do_start();
        for (int i = 1; i <= 4; i++) begin
            sum_valid = 1; sum_in = 5'(i);
            tick();
            if (i == 3) begin
                checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL clear_refill_early: got %b expected 0", acc_valid); end
            end
        end
        sum_valid = 0;
        checks++; if (acc_valid !== 1'b1 || acc_out !== 8'd10) begin errors++; $display("FAIL clear_refill: got valid=%b acc=%0d expected 1 10", acc_valid, acc_out); end
        go_idle();
    endtask

    task automatic test_async_reset();
        do_start();
        sum_valid = 1; sum_in = 5; tick(); tick();
        sum_valid = 0;
        #3 rst = 1;
        #1;
        checks++; if (acc_out !== 8'd0 || busy !== 1'b0 || sum_ready !== 1'b0 || acc_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset: got acc=%0d busy=%b ready=%b valid=%b ovf=%b expected all 0", acc_out, busy, sum_ready, acc_valid, ovf);
        end
        #1 rst = 0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got busy=%b expected 0", busy); end
        do_start();
        for (int i = 0; i < 4; i++) begin
            sum_valid = 1; sum_in = 5;
            tick();
        end
        sum_valid = 0;
        checks++; if (acc_valid !== 1'b1 || acc_out !== 8'd20) begin errors++; $display("FAIL reset_new_frame: got valid=%b acc=%0d expected 1 20", acc_valid, acc_out); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        do_start();
        sum_valid = 1; sum_in = 1; acc_ready = 1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 4 || c == 9) begin
                checks++; if (acc_valid !== 1'b1 || acc_out !== 8'd4) begin errors++; $display("FAIL b2b_frame_c%0d: got valid=%b acc=%0d expected 1 4", c, acc_valid, acc_out); end
            end else begin
                checks++; if (busy !== 1'b1 || acc_valid !== 1'b0) begin errors++; $display("FAIL b2b_accum_c%0d: got busy=%b valid=%b expected 1 0", c, busy, acc_valid); end
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_saturate();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
